// File: rtl/lsu_apb_master.sv
// Purpose: CPU load/store front end that turns one memory request into one APB transfer with lane steering.
// Latency: req_ready 3 cycles after acceptance with zero wait states; 1 cycle for illegal or misaligned requests.
// Backpressure: CPU stalls until the req_ready pulse; PREADY wait states stretch ACCESS up to TIMEOUT cycles, then abort.
module lsu_apb_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  storeType,
    input  logic [2:0]  loadType,
    output logic        req_ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    // Counter must reach TIMEOUT-1; TIMEOUT is expected to be at least 1.
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    addr_lo;
    logic [2:0]    ld_type;

    logic          type_ok;
    logic          align_ok;
    logic          reject;
    logic          timeout_hit;
    logic [1:0]    size;
    logic [3:0]    st_strb;
    logic [31:0]   st_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    // Decode the incoming request: access size, type legality, alignment and store lane steering.
    always_comb begin
        size     = 2'd0;
        type_ok  = 1'b0;
        align_ok = 1'b1;
        st_strb  = 4'b0000;
        st_data  = 32'h0;
        if (req_we) begin
            size    = storeType;
            type_ok = (storeType != 2'b11);
            case (storeType)
                2'b00: begin
                    st_strb = 4'b0001 << req_addr[1:0];
                    st_data = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    st_strb = req_addr[1] ? 4'b1100 : 4'b0011;
                    st_data = {2{req_wdata[15:0]}};
                end
                default: begin
                    st_strb = 4'b1111;
                    st_data = req_wdata;
                end
            endcase
        end else begin
            size    = loadType[1:0];
            type_ok = (loadType inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        case (size)
            2'd1:    align_ok = ~req_addr[0];
            2'd2:    align_ok = (req_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    assign reject      = ~type_ok | ~align_ok;
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

    // Pick the addressed lane out of PRDATA and extend it according to the latched load type.
    always_comb begin
        ld_byte = PRDATA[{addr_lo, 3'b000} +: 8];
        ld_half = addr_lo[1] ? PRDATA[31:16] : PRDATA[15:0];
        case (ld_type)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = PRDATA;
        endcase
    end

    // Next-state sequencing; rejected requests skip straight to DONE without touching the bus.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = reject ? DONE : SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Registered APB and CPU-side outputs, request latches and the wait-state counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_ready <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'h0;
            PADDR     <= 32'h0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= 32'h0;
            PSTRB     <= 4'b0000;
            wait_cnt  <= '0;
            addr_lo   <= 2'b00;
            ld_type   <= 3'b000;
        end else begin
            // Completion flags are single-cycle pulses.
            req_ready <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (reject) begin
                            req_ready <= 1'b1;
                            err       <= 1'b1;
                        end else begin
                            PSEL     <= 1'b1;
                            PADDR    <= {req_addr[31:2], 2'b00};
                            PWRITE   <= req_we;
                            PWDATA   <= st_data;
                            PSTRB    <= st_strb;
                            addr_lo  <= req_addr[1:0];
                            ld_type  <= loadType;
                            wait_cnt <= '0;
                        end
                    end
                end
                SETUP: PENABLE <= 1'b1;
                ACCESS: begin
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        req_ready <= 1'b1;
                        err       <= PSLVERR;
                        // Stores leave rdata alone; a failed load returns zero.
                        if (!PWRITE) rdata <= PSLVERR ? 32'h0 : ld_data;
                    end else if (timeout_hit) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        req_ready <= 1'b1;
                        err       <= 1'b1;
                        rdata     <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_apb_master.sv
// Purpose: directed self-checking bench for lsu_apb_master with a transaction-timeline reference model.
// Latency: each request is checked cycle by cycle from acceptance to the cycle after req_ready.
// Backpressure: the bench plays the APB completer, inserting a chosen number of wait states per request.
module tb_lsu_apb_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  storeType;
    logic [2:0]  loadType;
    logic        req_ready;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit in_rst   = 1'b1;

    // Reference model of the transaction in flight.
    bit          act = 1'b0;
    int          e0 = 0;
    int          m_done = 0;
    bit          m_bad, m_to, m_we, m_slv, m_err;
    logic [31:0] m_paddr, m_wdata, m_ld;
    logic [3:0]  m_strb;
    logic [31:0] rdata_exp = 32'h0;

    lsu_apb_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .storeType(storeType), .loadType(loadType),
        .req_ready(req_ready), .rdata(rdata), .err(err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    // Edge counter and record of whether the last edge sampled reset asserted.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        in_rst <= !reset;
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    // Per-cycle comparison of every meaningful DUT output against the timeline model.
    always @(negedge clk) begin : compare
        bit e_sel, e_en, e_rr;
        int off;
        e_sel = 1'b0;
        e_en  = 1'b0;
        e_rr  = 1'b0;
        if (in_rst) begin
            rdata_exp = 32'h0;
            chk("rst_PADDR", PADDR, 32'h0);
            chk("rst_PWDATA", PWDATA, 32'h0);
            chk("rst_PSTRB", PSTRB, 32'h0);
            chk("rst_PWRITE", PWRITE, 32'h0);
        end else if (act && cyc >= e0) begin
            off = cyc - e0;
            if (m_bad) begin
                e_rr = (off == 0);
            end else if (off < m_done) begin
                e_sel = 1'b1;
                e_en  = (off > 0);
            end else if (off == m_done) begin
                e_rr = 1'b1;
                if (m_to)       rdata_exp = 32'h0;
                else if (!m_we) rdata_exp = m_slv ? 32'h0 : m_ld;
            end
        end
        if (e_rr) chk("err", err, m_err);
        if (e_sel) begin
            chk("PADDR", PADDR, m_paddr);
            chk("PWRITE", PWRITE, m_we);
            chk("PWDATA", PWDATA, m_wdata);
            chk("PSTRB", PSTRB, m_strb);
        end
        chk("PSEL", PSEL, e_sel);
        chk("PENABLE", PENABLE, e_en);
        chk("req_ready", req_ready, e_rr);
        chk("rdata", rdata, rdata_exp);
    end

    // Issue one request, act as APB completer, and check hand-computed literals at SETUP and completion.
    // nwait >= TO means the completer never answers; rst_at >= 0 asserts reset at that cycle offset.
    task automatic run(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] st, input logic [2:0] lt, input int nwait, input bit slv,
                       input logic [31:0] prd, input int rst_at, input logic [3:0] l_strb,
                       input logic [31:0] l_wd, input bit l_err, input logic [31:0] l_rd);
        int          size;
        bit          legal;
        int          off;
        bit          rdy;
        logic [31:0] v;
        if (we) begin
            legal = (st != 2'd3);
            size  = 1 << st;
        end else begin
            legal = (lt == 3'd0) || (lt == 3'd1) || (lt == 3'd2) || (lt == 3'd4) || (lt == 3'd5);
            size  = 1 << lt[1:0];
        end
        m_bad   = !legal || ((addr & 32'(size - 1)) != 32'h0);
        m_to    = !m_bad && (nwait >= TO);
        m_done  = m_bad ? 0 : (m_to ? TO + 1 : 2 + nwait);
        m_we    = we;
        m_slv   = slv;
        m_err   = m_bad || m_to || slv;
        m_paddr = addr & ~32'h3;
        m_strb  = 4'h0;
        m_wdata = 32'h0;
        if (we) begin
            case (st)
                2'd0: begin m_strb = 4'(1 << addr[1:0]); m_wdata = {24'h0, wdata[7:0]} * 32'h0101_0101; end
                2'd1: begin m_strb = 4'(3 << addr[1:0]); m_wdata = {16'h0, wdata[15:0]} * 32'h0001_0001; end
                default: begin m_strb = 4'hF; m_wdata = wdata; end
            endcase
        end
        v = prd >> (8 * addr[1:0]);
        case (lt)
            3'd0: begin v = v & 32'hFF;   if (v[7])  v = v | 32'hFFFF_FF00; end
            3'd1: begin v = v & 32'hFFFF; if (v[15]) v = v | 32'hFFFF_0000; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = prd;
        endcase
        m_ld = v;

        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        storeType = st; loadType = lt; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = prd;
        e0  = cyc + 1;
        act = 1'b1;
        for (int k = 0; k <= m_done; k++) begin
            @(posedge clk); #1;
            off = cyc - e0;
            if (off == rst_at) begin
                reset  = 1'b0;
                PREADY = 1'b0;
                @(posedge clk); #1;
                reset     = 1'b1;
                act       = 1'b0;
                req_valid = 1'b0;
                return;
            end
            rdy     = !m_bad && !m_to && (off == 1 + nwait);
            PREADY  = rdy;
            PSLVERR = rdy && slv;
            if (rst_at < 0 && off == 0 && !m_bad) begin
                chk("lit_PSTRB", PSTRB, l_strb);
                chk("lit_PWDATA", PWDATA, l_wd);
            end
            if (rst_at < 0 && off == m_done) begin
                chk("lit_err", err, l_err);
                chk("lit_rdata", rdata, l_rd);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        act       = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        storeType = 2'b00; loadType = 3'b000; PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Stores: word, byte lane 3, halfword upper, byte lane 1 with one wait, halfword lower.
        run(1, 32'h1000_0004, 32'hDEAD_BEEF, 2'b10, 3'b010, 0, 0, 32'h0, -1, 4'hF, 32'hDEAD_BEEF, 0, 32'h0);
        run(1, 32'h1000_0003, 32'h0000_00A5, 2'b00, 3'b010, 0, 0, 32'h0, -1, 4'h8, 32'hA5A5_A5A5, 0, 32'h0);
        run(1, 32'h1000_0002, 32'h0000_1234, 2'b01, 3'b010, 0, 0, 32'h0, -1, 4'hC, 32'h1234_1234, 0, 32'h0);
        run(1, 32'h1000_0001, 32'hFFFF_FF3C, 2'b00, 3'b010, 1, 0, 32'h0, -1, 4'h2, 32'h3C3C_3C3C, 0, 32'h0);
        run(1, 32'h1000_0000, 32'hCAFE_5678, 2'b01, 3'b010, 0, 0, 32'h0, -1, 4'h3, 32'h5678_5678, 0, 32'h0);
        // Loads from PRDATA 0x80FF7F01 with each extension rule.
        run(0, 32'h2000_0003, 32'h0, 2'b00, 3'b000, 0, 0, 32'h80FF_7F01, -1, 4'h0, 32'h0, 0, 32'hFFFF_FF80);
        run(0, 32'h2000_0003, 32'h0, 2'b00, 3'b100, 0, 0, 32'h80FF_7F01, -1, 4'h0, 32'h0, 0, 32'h0000_0080);
        run(0, 32'h2000_0002, 32'h0, 2'b00, 3'b001, 0, 0, 32'h80FF_7F01, -1, 4'h0, 32'h0, 0, 32'hFFFF_80FF);
        run(0, 32'h2000_0000, 32'h0, 2'b00, 3'b101, 0, 0, 32'h80FF_7F01, -1, 4'h0, 32'h0, 0, 32'h0000_7F01);
        run(0, 32'h2000_0000, 32'h0, 2'b00, 3'b010, 2, 0, 32'h80FF_7F01, -1, 4'h0, 32'h0, 0, 32'h80FF_7F01);
        // Rejected requests: rdata holds its previous value.
        run(0, 32'h2000_0002, 32'h0, 2'b00, 3'b010, 0, 0, 32'h0, -1, 4'h0, 32'h0, 1, 32'h80FF_7F01);
        run(1, 32'h1000_0000, 32'h1, 2'b11, 3'b010, 0, 0, 32'h0, -1, 4'h0, 32'h0, 1, 32'h80FF_7F01);
        run(0, 32'h2000_0000, 32'h0, 2'b00, 3'b011, 0, 0, 32'h0, -1, 4'h0, 32'h0, 1, 32'h80FF_7F01);
        run(0, 32'h2000_0001, 32'h0, 2'b00, 3'b001, 0, 0, 32'h0, -1, 4'h0, 32'h0, 1, 32'h80FF_7F01);
        run(1, 32'h1000_0006, 32'h2, 2'b10, 3'b010, 0, 0, 32'h0, -1, 4'h0, 32'h0, 1, 32'h80FF_7F01);
        // Slave error after three wait states, then a clean load, then a timeout.
        run(0, 32'h2000_0000, 32'h0, 2'b00, 3'b000, 3, 1, 32'h1111_1111, -1, 4'h0, 32'h0, 1, 32'h0);
        run(0, 32'h2000_0004, 32'h0, 2'b00, 3'b010, 0, 0, 32'h1357_9BDF, -1, 4'h0, 32'h0, 0, 32'h1357_9BDF);
        run(0, 32'h2000_0008, 32'h0, 2'b00, 3'b010, TO, 0, 32'hFFFF_FFFF, -1, 4'h0, 32'h0, 1, 32'h0);
        // Reset during ACCESS, then normal traffic resumes.
        run(0, 32'h3000_0000, 32'h0, 2'b00, 3'b010, 5, 0, 32'h55AA_55AA, 2, 4'h0, 32'h0, 0, 32'h0);
        run(0, 32'h2000_0002, 32'h0, 2'b00, 3'b101, 0, 0, 32'hABCD_0000, -1, 4'h0, 32'h0, 0, 32'h0000_ABCD);
        run(1, 32'h1000_0008, 32'h0BAD_F00D, 2'b10, 3'b010, 1, 0, 32'h0, -1, 4'hF, 32'h0BAD_F00D, 0, 32'h0000_ABCD);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_apb_master.md
LSU_APB_MASTER -- requirements
Module: lsu_apb_master

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum ACCESS cycles without PREADY before abort.
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low; asserted (0) sampled on rising clk.
REQ-004 req_valid  input  1  CPU memory request present; held stable until req_ready.
REQ-005 req_we  input  1  1=store, 0=load.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_wdata  input  32  store data (rs2).
REQ-008 storeType  input  2  00=SB, 01=SH, 10=SW, 11=illegal.
REQ-009 loadType  input  3  000=LB, 001=LH, 010=LW, 100=LBU, 101=LHU, others illegal.
REQ-010 req_ready  output  1  one-cycle completion pulse; CPU stall released.
REQ-011 rdata  output  32  aligned and extended load result.
REQ-012 err  output  1  completion with error; meaningful only while req_ready=1.
REQ-013 PADDR  output  32; PSEL  output  1; PENABLE  output  1; PWRITE  output  1; PWDATA  output  32; PSTRB  output  4  APB master outputs.
REQ-014 PRDATA  input  32; PREADY  input  1; PSLVERR  input  1  APB completer responses.

Function
REQ-015 FSM states: IDLE, SETUP, ACCESS, DONE; all outputs registered.
REQ-016 IDLE: on req_valid=1 with legal type and aligned address, latch request and go to SETUP; otherwise remain IDLE.
REQ-017 IDLE: on req_valid=1 with illegal type, or misaligned address (half with addr[0]=1, word with addr[1:0]!=00), go to DONE with err=1 and no APB activity.
REQ-018 SETUP: PSEL=1, PENABLE=0, for exactly one cycle, then ACCESS.
REQ-019 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA/PSTRB stable from SETUP through ACCESS.
REQ-020 ACCESS with PREADY=1: capture PRDATA and PSLVERR, go to DONE; PSEL/PENABLE return to 0 in DONE.
REQ-021 ACCESS wait counter increments each cycle with PREADY=0; at TIMEOUT consecutive wait cycles, abort to DONE with err=1 and rdata=0.
REQ-022 DONE: req_ready=1 for exactly one cycle, err per cause, then IDLE; req_valid is ignored in DONE (no double issue).
REQ-023 Minimum latency: request accepted at edge k, SETUP k+1, ACCESS k+2, req_ready high in cycle k+3 with zero wait states.
REQ-024 PADDR = {req_addr[31:2], 2'b00}; PWRITE = req_we.
REQ-025 Store lanes: SB -> PSTRB = 0001 << addr[1:0], PWDATA = byte replicated x4; SH -> PSTRB = 0011 (addr[1]=0) or 1100 (addr[1]=1), PWDATA = halfword replicated x2; SW -> 1111, wdata unchanged.
REQ-026 Loads: PSTRB=0000, PWDATA=0.
REQ-027 Load extraction: byte lane addr[1:0] or halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-028 PSLVERR=1 at completion: err=1; loads return rdata=0; store considered failed.
REQ-029 rdata holds last value until next DONE; unchanged by stores and error completions other than REQ-021/REQ-028.

Reset
REQ-030 reset=0: state IDLE, wait counter 0, and req_ready, err, rdata, PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB all 0 on next edge.
REQ-031 reset mid-transaction (SETUP/ACCESS/DONE): PSEL/PENABLE drop to 0 on next edge; no req_ready pulse for the aborted request.

Verification
REQ-032 SW addr 0x1000_0004 wdata 0xDEAD_BEEF, PREADY=1 -> SETUP PADDR=0x1000_0004 PSTRB=1111 PWRITE=1, req_ready at k+3, err=0.
REQ-033 SB addr 0x...0003 wdata 0x0000_00A5 -> PSTRB=1000, PWDATA=0xA5A5_A5A5; SH addr 0x...0002 wdata 0x1234 -> PSTRB=1100, PWDATA=0x1234_1234.
REQ-034 PRDATA=0x80FF_7F01: LB addr+3 -> 0xFFFF_FF80; LBU addr+3 -> 0x0000_0080; LH addr+2 -> 0xFFFF_80FF; LHU addr+0 -> 0x0000_7F01.
REQ-035 LW addr 0x...0002 (misaligned) -> no PSEL, req_ready one cycle later with err=1; storeType=11 -> same.
REQ-036 PREADY held low 3 cycles, then 1 with PSLVERR=1 on load -> req_ready at k+6, err=1, rdata=0; PREADY never high -> abort after TIMEOUT wait cycles, err=1.
REQ-037 reset=0 during ACCESS -> PSEL=0 next edge, no req_ready; new request after release completes normally.
